// File: rtl/pcie_axi_target_ram.sv
// AXI4 slave backed by a byte-strobed dual-port RAM, terminating the PCIe target (BAR) port.
// Latency: B one cycle after the final W beat; first R beat two cycles after the AR handshake.
// Backpressure: a 2-entry read skid buffer holds R stable while s_rready=0; AW/W/AR stall only on FSM state.
module pcie_axi_target_ram #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 64,
    parameter int ID_W   = 8,
    parameter int MEM_AW = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic [ID_W-1:0]     s_awid,
    input  logic [7:0]          s_awlen,
    input  logic [2:0]          s_awsize,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_wlast,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [ID_W-1:0]     s_bid,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    output logic                s_bid_par,
    input  logic [ADDR_W-1:0]   s_araddr,
    input  logic [ID_W-1:0]     s_arid,
    input  logic [7:0]          s_arlen,
    input  logic [2:0]          s_arsize,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [ID_W-1:0]     s_rid,
    output logic [1:0]          s_rresp,
    output logic                s_rlast,
    output logic                s_rvalid,
    input  logic                s_rready,
    output logic [DATA_W/8-1:0] s_rdata_par,
    output logic                s_rid_par,
    output logic                wlast_err
);
    localparam int STRB_W = DATA_W / 8;
    localparam int BA_W   = MEM_AW + 5;     // byte-address bits that reach the RAM; higher bits alias
    localparam int DEPTH  = 1 << MEM_AW;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    // ------------------------------------------------------------------
    // Common
    // ------------------------------------------------------------------
    logic r_en;   // low during reset; keeps the ready outputs low until reset has been released

    // Ready enable: cleared by reset, set on the first clock with reset released.
    always_ff @(posedge clk) begin
        if (rst) r_en <= 1'b0;
        else     r_en <= 1'b1;
    end

    logic w_unused_addr;
    assign w_unused_addr = ^{s_awaddr[ADDR_W-1:BA_W], s_araddr[ADDR_W-1:BA_W]};

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    wstate_t           r_wstate, w_wstate_nxt;
    logic [BA_W-1:0]   r_waddr;
    logic [ID_W-1:0]   r_wid;
    logic [7:0]        r_wlen;
    logic [7:0]        r_wcnt;
    logic [2:0]        r_wsize;
    logic              r_wlast_err;
    logic              w_aw_hs, w_w_hs, w_w_final;
    logic [BA_W-1:0]   w_wstep;
    logic [MEM_AW-1:0] w_wr_idx;

    assign w_aw_hs   = s_awvalid & s_awready;
    assign w_w_hs    = s_wvalid & s_wready;
    assign w_w_final = (r_wcnt == r_wlen);
    assign w_wstep   = {{(BA_W-1){1'b0}}, 1'b1} << r_wsize;
    assign w_wr_idx  = r_waddr[BA_W-1:5];

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_wstate <= W_IDLE;
        else     r_wstate <= w_wstate_nxt;
    end

    // Write FSM next state and channel handshake outputs; termination is by beat count, not WLAST.
    always_comb begin
        w_wstate_nxt = r_wstate;
        s_awready    = 1'b0;
        s_wready     = 1'b0;
        s_bvalid     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                s_awready = r_en;
                if (s_awvalid && r_en) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                s_wready = 1'b1;
                if (s_wvalid && w_w_final) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                s_bvalid = 1'b1;
                if (s_bready) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // Write burst context: latch on AW, advance INCR address and beat count per W beat, flag WLAST misuse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_waddr     <= '0;
            r_wid       <= '0;
            r_wlen      <= '0;
            r_wcnt      <= '0;
            r_wsize     <= '0;
            r_wlast_err <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_waddr <= s_awaddr[BA_W-1:0];
                r_wid   <= s_awid;
                r_wlen  <= s_awlen;
                r_wsize <= s_awsize;
                r_wcnt  <= '0;
            end
            if (w_w_hs) begin
                r_waddr <= r_waddr + w_wstep;
                r_wcnt  <= r_wcnt + 8'd1;
                if (s_wlast != w_w_final) r_wlast_err <= 1'b1;
            end
        end
    end

    assign s_bid     = r_wid;
    assign s_bresp   = 2'b00;
    assign s_bid_par = ~^s_bid;
    assign wlast_err = r_wlast_err;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    rstate_t           r_rstate, w_rstate_nxt;
    logic [BA_W-1:0]   r_raddr;
    logic [ID_W-1:0]   r_rid;
    logic [7:0]        r_rlen;
    logic [2:0]        r_rsize;
    logic [8:0]        r_iss_cnt;          // beats already sent to the RAM this burst
    logic              r_rq_vld, r_rq_last; // RAM output register holds a beat
    logic [DATA_W-1:0] r_rd_dat;
    logic [DATA_W-1:0] r_sk_dat [2];
    logic [1:0]        r_sk_last;
    logic              r_sk_wp, r_sk_rp;
    logic [1:0]        r_sk_cnt;
    logic              w_ar_hs, w_r_hs, w_rd_en, w_iss_left, w_room;
    logic [2:0]        w_occ;
    logic [BA_W-1:0]   w_rstep;
    logic [MEM_AW-1:0] w_rd_idx;

    assign w_ar_hs    = s_arvalid & s_arready;
    assign w_r_hs     = s_rvalid & s_rready;
    assign w_rstep    = {{(BA_W-1){1'b0}}, 1'b1} << r_rsize;
    assign w_rd_idx   = r_raddr[BA_W-1:5];
    assign w_iss_left = (r_iss_cnt <= {1'b0, r_rlen});
    // A beat may be issued only if the skid buffer can still absorb it after this cycle's pop.
    assign w_occ      = {1'b0, r_sk_cnt} + {2'b00, r_rq_vld};
    assign w_room     = (w_occ < (3'd2 + {2'b00, w_r_hs}));
    assign w_rd_en    = (r_rstate == R_DATA) && w_iss_left && w_room && !rst;

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_rstate <= R_IDLE;
        else     r_rstate <= w_rstate_nxt;
    end

    // Read FSM next state and AR ready; the burst ends on the handshake of the RLAST beat.
    always_comb begin
        w_rstate_nxt = r_rstate;
        s_arready    = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                s_arready = r_en;
                if (s_arvalid && r_en) w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                if (w_r_hs && s_rlast) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Read burst context, RAM read stage and 2-entry output skid buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_raddr   <= '0;
            r_rid     <= '0;
            r_rlen    <= '0;
            r_rsize   <= '0;
            r_iss_cnt <= '0;
            r_rq_vld  <= 1'b0;
            r_rq_last <= 1'b0;
            r_sk_dat  <= '{default: '0};
            r_sk_last <= '0;
            r_sk_wp   <= 1'b0;
            r_sk_rp   <= 1'b0;
            r_sk_cnt  <= '0;
        end else begin
            if (w_ar_hs) begin
                r_raddr   <= s_araddr[BA_W-1:0];
                r_rid     <= s_arid;
                r_rlen    <= s_arlen;
                r_rsize   <= s_arsize;
                r_iss_cnt <= '0;
            end
            if (w_rd_en) begin
                r_raddr   <= r_raddr + w_rstep;
                r_iss_cnt <= r_iss_cnt + 9'd1;
            end
            r_rq_vld  <= w_rd_en;
            r_rq_last <= w_rd_en && (r_iss_cnt == {1'b0, r_rlen});
            if (r_rq_vld) begin
                r_sk_dat[r_sk_wp]  <= r_rd_dat;
                r_sk_last[r_sk_wp] <= r_rq_last;
                r_sk_wp            <= ~r_sk_wp;
            end
            if (w_r_hs) r_sk_rp <= ~r_sk_rp;
            r_sk_cnt <= r_sk_cnt + {1'b0, r_rq_vld} - {1'b0, w_r_hs};
        end
    end

    assign s_rvalid  = (r_sk_cnt != 2'd0);
    assign s_rdata   = r_sk_dat[r_sk_rp];
    assign s_rlast   = s_rvalid & r_sk_last[r_sk_rp];
    assign s_rid     = r_rid;
    assign s_rresp   = 2'b00;
    assign s_rid_par = ~^s_rid;

    // Per-byte odd parity over the registered read data.
    always_comb begin
        s_rdata_par = '0;
        for (int i = 0; i < STRB_W; i++) s_rdata_par[i] = ~^s_rdata[8*i +: 8];
    end

    // ------------------------------------------------------------------
    // RAM: byte-strobed write port, registered read port (read-first on same-word collision)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [DEPTH];

    // RAM write of enabled byte lanes and synchronous read; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_w_hs && !rst) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_wstrb[b]) r_mem[w_wr_idx][8*b +: 8] <= s_wdata[8*b +: 8];
            end
        end
        if (w_rd_en) r_rd_dat <= r_mem[w_rd_idx];
    end
endmodule

// File: tb/tb_pcie_axi_target_ram.sv
// Self-checking bench for pcie_axi_target_ram against a byte-level memory model.
// Latency: checks first-beat and response timing relative to handshakes.
// Backpressure: drives fixed and random s_rready patterns and checks R stability while stalled.
module tb_pcie_axi_target_ram;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [63:0]  s_awaddr = '0;
    logic [7:0]   s_awid = '0;
    logic [7:0]   s_awlen = '0;
    logic [2:0]   s_awsize = '0;
    logic         s_awvalid = 1'b0;
    logic         s_awready;
    logic [255:0] s_wdata = '0;
    logic [31:0]  s_wstrb = '0;
    logic         s_wlast = 1'b0;
    logic         s_wvalid = 1'b0;
    logic         s_wready;
    logic [7:0]   s_bid;
    logic [1:0]   s_bresp;
    logic         s_bvalid;
    logic         s_bready = 1'b1;
    logic         s_bid_par;
    logic [63:0]  s_araddr = '0;
    logic [7:0]   s_arid = '0;
    logic [7:0]   s_arlen = '0;
    logic [2:0]   s_arsize = '0;
    logic         s_arvalid = 1'b0;
    logic         s_arready;
    logic [255:0] s_rdata;
    logic [7:0]   s_rid;
    logic [1:0]   s_rresp;
    logic         s_rlast;
    logic         s_rvalid;
    logic         s_rready = 1'b0;
    logic [31:0]  s_rdata_par;
    logic         s_rid_par;
    logic         wlast_err;

    pcie_axi_target_ram dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid_par(s_bid_par),
        .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rid(s_rid), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
        .s_rready(s_rready), .s_rdata_par(s_rdata_par), .s_rid_par(s_rid_par), .wlast_err(wlast_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference memory and burst buffers
    logic [255:0] mdl [1024];
    logic [255:0] wdat [256];
    logic [31:0]  wstb [256];
    logic         wlst [256];
    logic [255:0] rdat [256];
    logic         rlst [256];
    logic [7:0]   rid_c [256];
    logic [1:0]   rresp_c [256];
    logic [31:0]  rpar_c [256];
    int           rd_unstable, rd_first_lat, b_wait, rd_mode;
    logic [7:0]   b_id;
    logic [1:0]   b_resp;
    logic         b_par;

    function automatic int widx(input logic [63:0] a, input int k, input logic [2:0] sz);
        logic [63:0] ba;
        ba = a + 64'(k) * (64'd1 << sz);
        return int'((ba / 64'd32) % 64'd1024);
    endfunction

    function automatic logic [31:0] exp_par(input logic [255:0] d);
        logic [31:0] p;
        for (int b = 0; b < 32; b++) p[b] = (($countones(d[8*b +: 8]) % 2) == 0);
        return p;
    endfunction

    function automatic logic odd_par8(input logic [7:0] v);
        return (($countones(v) % 2) == 0);
    endfunction

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic fill(input int len);
        for (int k = 0; k <= len; k++) begin
            wdat[k] = rnd256();
            wstb[k] = 32'hFFFF_FFFF;
            wlst[k] = (k == len);
        end
    endtask

    task automatic timeout_fail(input string what);
        n_cmp++; n_fail++;
        $display("FAIL timeout %s: handshake not seen, required within budget", what);
    endtask

    task automatic axi_write(input logic [63:0] addr, input logic [7:0] id, input logic [7:0] len,
                             input logic [2:0] size);
        int cnt;
        @(negedge clk);
        s_awaddr = addr; s_awid = id; s_awlen = len; s_awsize = size; s_awvalid = 1'b1;
        cnt = 0;
        while (!s_awready && cnt < 200) begin @(negedge clk); cnt++; end
        if (cnt >= 200) timeout_fail("aw");
        @(negedge clk);
        s_awvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            s_wdata = wdat[k]; s_wstrb = wstb[k]; s_wlast = wlst[k]; s_wvalid = 1'b1;
            cnt = 0;
            while (!s_wready && cnt < 200) begin @(negedge clk); cnt++; end
            if (cnt >= 200) timeout_fail("w");
            @(negedge clk);
        end
        s_wvalid = 1'b0; s_wlast = 1'b0;
        b_wait = 0;
        while (!s_bvalid && b_wait < 200) begin @(negedge clk); b_wait++; end
        if (b_wait >= 200) timeout_fail("b");
        b_id = s_bid; b_resp = s_bresp; b_par = s_bid_par;
        @(negedge clk);
        for (int k = 0; k <= int'(len); k++) begin
            for (int b = 0; b < 32; b++)
                if (wstb[k][b]) mdl[widx(addr, k, size)][8*b +: 8] = wdat[k][8*b +: 8];
        end
    endtask

    task automatic axi_read(input logic [63:0] addr, input logic [7:0] id, input logic [7:0] len,
                            input logic [2:0] size);
        int cnt, nb, cyc;
        logic held;
        logic [255:0] pd; logic pl; logic [7:0] pid; logic [31:0] pp;
        logic [3:0] pat;
        pat = 4'b1001;
        @(negedge clk);
        s_araddr = addr; s_arid = id; s_arlen = len; s_arsize = size; s_arvalid = 1'b1;
        cnt = 0;
        while (!s_arready && cnt < 200) begin @(negedge clk); cnt++; end
        if (cnt >= 200) timeout_fail("ar");
        @(negedge clk);
        s_arvalid = 1'b0;
        nb = 0; cyc = 0; held = 1'b0; rd_unstable = 0; rd_first_lat = -1;
        pd = '0; pl = 1'b0; pid = '0; pp = '0;
        while (nb <= int'(len) && cyc < 2000) begin
            if (held && (s_rdata !== pd || s_rlast !== pl || s_rid !== pid || s_rdata_par !== pp))
                rd_unstable++;
            if (rd_mode == 0)      s_rready = 1'b1;
            else if (rd_mode == 1) s_rready = pat[3 - (cyc % 4)];
            else                   s_rready = 1'($urandom_range(0, 1));
            if (s_rvalid && rd_first_lat < 0) rd_first_lat = cyc;
            if (s_rvalid && s_rready) begin
                rdat[nb] = s_rdata; rlst[nb] = s_rlast; rid_c[nb] = s_rid;
                rresp_c[nb] = s_rresp; rpar_c[nb] = s_rdata_par;
                nb++; held = 1'b0;
            end else if (s_rvalid) begin
                held = 1'b1; pd = s_rdata; pl = s_rlast; pid = s_rid; pp = s_rdata_par;
            end else begin
                held = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        s_rready = 1'b0;
        if (cyc >= 2000) timeout_fail("r");
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (s_awready !== 1'b0) begin n_fail++; $display("FAIL rst_awready got %b exp 0", s_awready); end
        n_cmp++; if (s_wready !== 1'b0) begin n_fail++; $display("FAIL rst_wready got %b exp 0", s_wready); end
        n_cmp++; if (s_bvalid !== 1'b0) begin n_fail++; $display("FAIL rst_bvalid got %b exp 0", s_bvalid); end
        n_cmp++; if (s_arready !== 1'b0) begin n_fail++; $display("FAIL rst_arready got %b exp 0", s_arready); end
        n_cmp++; if (s_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid got %b exp 0", s_rvalid); end
        n_cmp++; if (s_rlast !== 1'b0) begin n_fail++; $display("FAIL rst_rlast got %b exp 0", s_rlast); end
        n_cmp++; if (wlast_err !== 1'b0) begin n_fail++; $display("FAIL rst_wlast_err got %b exp 0", wlast_err); end
        n_cmp++; if (s_bid !== 8'h00) begin n_fail++; $display("FAIL rst_bid got %h exp 00", s_bid); end
        n_cmp++; if (s_rid !== 8'h00) begin n_fail++; $display("FAIL rst_rid got %h exp 00", s_rid); end
        n_cmp++; if (s_rdata !== 256'h0) begin n_fail++; $display("FAIL rst_rdata got %h exp 0", s_rdata); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (s_awready !== 1'b1) begin n_fail++; $display("FAIL post_rst_awready got %b exp 1", s_awready); end
        n_cmp++; if (s_arready !== 1'b1) begin n_fail++; $display("FAIL post_rst_arready got %b exp 1", s_arready); end
    endtask

    task automatic test_single();
        logic [7:0] id, id2;
        id = 8'($urandom); id2 = 8'($urandom);
        wdat[0] = {32{8'hA5}}; wstb[0] = 32'hFFFF_FFFF; wlst[0] = 1'b1;
        axi_write(64'h40, id, 8'd0, 3'd5);
        n_cmp++; if (b_wait !== 0) begin n_fail++; $display("FAIL single_b_lat got %0d exp 0", b_wait); end
        n_cmp++; if (b_id !== id) begin n_fail++; $display("FAIL single_bid got %h exp %h", b_id, id); end
        n_cmp++; if (b_resp !== 2'b00) begin n_fail++; $display("FAIL single_bresp got %b exp 00", b_resp); end
        n_cmp++; if (b_par !== odd_par8(id)) begin n_fail++; $display("FAIL single_bid_par got %b exp %b", b_par, odd_par8(id)); end
        n_cmp++; if (wlast_err !== 1'b0) begin n_fail++; $display("FAIL single_wlast_err got %b exp 0", wlast_err); end
        rd_mode = 0;
        axi_read(64'h40, id2, 8'd0, 3'd5);
        n_cmp++; if (rd_first_lat !== 2) begin n_fail++; $display("FAIL single_r_lat got %0d exp 2", rd_first_lat); end
        n_cmp++; if (rdat[0] !== {32{8'hA5}}) begin n_fail++; $display("FAIL single_rdata got %h exp a5..", rdat[0]); end
        n_cmp++; if (rlst[0] !== 1'b1) begin n_fail++; $display("FAIL single_rlast got %b exp 1", rlst[0]); end
        n_cmp++; if (rid_c[0] !== id2) begin n_fail++; $display("FAIL single_rid got %h exp %h", rid_c[0], id2); end
        n_cmp++; if (rresp_c[0] !== 2'b00) begin n_fail++; $display("FAIL single_rresp got %b exp 00", rresp_c[0]); end
        n_cmp++; if (rpar_c[0] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL single_rpar got %h exp ffffffff", rpar_c[0]); end
        n_cmp++; if (s_rid_par !== odd_par8(id2)) begin n_fail++; $display("FAIL single_rid_par got %b exp %b", s_rid_par, odd_par8(id2)); end
    endtask

    task automatic test_burst_backpressure();
        logic [255:0] e;
        for (int k = 0; k < 4; k++) begin
            wdat[k] = {32{8'(k + 1)}}; wstb[k] = 32'hFFFF_FFFF; wlst[k] = (k == 3);
        end
        axi_write(64'h100, 8'h3C, 8'd3, 3'd5);
        rd_mode = 1;
        axi_read(64'h100, 8'h5A, 8'd3, 3'd5);
        for (int k = 0; k < 4; k++) begin
            e = {32{8'(k + 1)}};
            n_cmp++; if (rdat[k] !== e) begin n_fail++; $display("FAIL burst_rdata beat %0d got %h exp %h", k, rdat[k], e); end
            n_cmp++; if (rlst[k] !== (k == 3)) begin n_fail++; $display("FAIL burst_rlast beat %0d got %b exp %b", k, rlst[k], k == 3); end
        end
        n_cmp++; if (rd_unstable !== 0) begin n_fail++; $display("FAIL burst_stall_stable got %0d changes exp 0", rd_unstable); end
        n_cmp++; if (s_arready !== 1'b1) begin n_fail++; $display("FAIL burst_arready_after got %b exp 1", s_arready); end
    endtask

    task automatic test_strobe();
        logic [255:0] e;
        e = {{28{8'hFF}}, {4{8'h00}}};
        wdat[0] = {32{8'hFF}}; wstb[0] = 32'hFFFF_FFFF; wlst[0] = 1'b1;
        axi_write(64'h40, 8'h11, 8'd0, 3'd5);
        wdat[0] = '0; wstb[0] = 32'h0000_000F;
        axi_write(64'h40, 8'h12, 8'd0, 3'd5);
        rd_mode = 0;
        axi_read(64'h40, 8'h13, 8'd0, 3'd5);
        n_cmp++; if (rdat[0] !== e) begin n_fail++; $display("FAIL strobe_rdata got %h exp %h", rdat[0], e); end
        n_cmp++; if (rdat[0] !== mdl[2]) begin n_fail++; $display("FAIL strobe_model got %h exp %h", rdat[0], mdl[2]); end
    endtask

    task automatic test_wrap();
        logic [255:0] d0, d1;
        fill(1);
        d0 = wdat[0]; d1 = wdat[1];
        axi_write(64'h7FE0, 8'h21, 8'd1, 3'd5);
        rd_mode = 0;
        axi_read(64'h0, 8'h22, 8'd1, 3'd2);
        n_cmp++; if (rdat[0] !== d1) begin n_fail++; $display("FAIL wrap_narrow0 got %h exp %h", rdat[0], d1); end
        n_cmp++; if (rdat[1] !== d1) begin n_fail++; $display("FAIL wrap_narrow1 got %h exp %h", rdat[1], d1); end
        n_cmp++; if (rlst[1] !== 1'b1) begin n_fail++; $display("FAIL wrap_rlast got %b exp 1", rlst[1]); end
        axi_read(64'hABCD_0000_0000_7FE0, 8'h23, 8'd0, 3'd5);
        n_cmp++; if (rdat[0] !== d0) begin n_fail++; $display("FAIL wrap_alias got %h exp %h", rdat[0], d0); end
    endtask

    task automatic test_random();
        logic [63:0] a; logic [7:0] len; logic [2:0] sz, rsz; logic [7:0] id;
        for (int it = 0; it < 12; it++) begin
            a = {$urandom, $urandom}; len = 8'($urandom_range(0, 7)); sz = 3'($urandom_range(0, 5));
            rsz = 3'($urandom_range(0, int'(sz))); id = 8'($urandom);
            fill(int'(len));
            axi_write(a, id, len, sz);
            fill(int'(len));
            for (int k = 0; k <= int'(len); k++) wstb[k] = $urandom;
            axi_write(a, id, len, sz);
            rd_mode = 2;
            axi_read(a, ~id, len, rsz);
            for (int k = 0; k <= int'(len); k++) begin
                n_cmp++;
                if (rdat[k] !== mdl[widx(a, k, rsz)] || rlst[k] !== (k == int'(len)) || rid_c[k] !== ~id
                    || rpar_c[k] !== exp_par(mdl[widx(a, k, rsz)])) begin
                    n_fail++;
                    $display("FAIL rand it %0d beat %0d got %h last %b exp %h last %b", it, k, rdat[k], rlst[k],
                             mdl[widx(a, k, rsz)], k == int'(len));
                end
            end
            n_cmp++; if (rd_unstable !== 0) begin n_fail++; $display("FAIL rand_stall_stable it %0d got %0d exp 0", it, rd_unstable); end
        end
    endtask

    task automatic test_concurrent_reset();
        time t0;
        int cyc, cnt;
        fill(7);
        axi_write(64'h1000, 8'h31, 8'd7, 3'd5);
        fill(7);
        rd_mode = 0;
        t0 = $time;
        fork
            axi_read(64'h1000, 8'h32, 8'd7, 3'd5);
            axi_write(64'h2000, 8'h33, 8'd7, 3'd5);
        join
        cyc = int'(($time - t0) / 10);
        n_cmp++; if (cyc > 14) begin n_fail++; $display("FAIL conc_parallel got %0d cycles exp <= 14", cyc); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (rdat[k] !== mdl[widx(64'h1000, k, 3'd5)]) begin n_fail++; $display("FAIL conc_rdata beat %0d got %h exp %h", k, rdat[k], mdl[widx(64'h1000, k, 3'd5)]); end
        end
        axi_read(64'h2000, 8'h34, 8'd7, 3'd5);
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (rdat[k] !== wdat[k]) begin n_fail++; $display("FAIL conc_wback beat %0d got %h exp %h", k, rdat[k], wdat[k]); end
        end
        // write burst interrupted by reset on beat 3
        fill(7);
        @(negedge clk);
        s_awaddr = 64'h3000; s_awid = 8'h35; s_awlen = 8'd7; s_awsize = 3'd5; s_awvalid = 1'b1;
        cnt = 0;
        while (!s_awready && cnt < 200) begin @(negedge clk); cnt++; end
        if (cnt >= 200) timeout_fail("rst_aw");
        @(negedge clk);
        s_awvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_wdata = wdat[k]; s_wstrb = '1; s_wlast = 1'b0; s_wvalid = 1'b1;
            cnt = 0;
            while (!s_wready && cnt < 200) begin @(negedge clk); cnt++; end
            if (cnt >= 200) timeout_fail("rst_w");
            @(negedge clk);
            mdl[widx(64'h3000, k, 3'd5)] = wdat[k];
        end
        s_wvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (s_bvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_bvalid got %b exp 0", s_bvalid); end
        n_cmp++; if (s_wready !== 1'b0) begin n_fail++; $display("FAIL midrst_wready got %b exp 0", s_wready); end
        n_cmp++; if (wlast_err !== 1'b0) begin n_fail++; $display("FAIL midrst_wlast_err got %b exp 0", wlast_err); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (s_awready !== 1'b1) begin n_fail++; $display("FAIL midrst_awready got %b exp 1", s_awready); end
        axi_read(64'h3000, 8'h36, 8'd2, 3'd5);
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (rdat[k] !== wdat[k]) begin n_fail++; $display("FAIL midrst_persist beat %0d got %h exp %h", k, rdat[k], wdat[k]); end
        end
    endtask

    task automatic test_wlast_err();
        n_cmp++; if (wlast_err !== 1'b0) begin n_fail++; $display("FAIL wlerr_before got %b exp 0", wlast_err); end
        fill(2);
        wlst[0] = 1'b0; wlst[1] = 1'b1; wlst[2] = 1'b0;
        axi_write(64'h4000, 8'h41, 8'd2, 3'd5);
        n_cmp++; if (b_wait !== 0) begin n_fail++; $display("FAIL wlerr_b_lat got %0d exp 0", b_wait); end
        n_cmp++; if (b_id !== 8'h41) begin n_fail++; $display("FAIL wlerr_bid got %h exp 41", b_id); end
        n_cmp++; if (wlast_err !== 1'b1) begin n_fail++; $display("FAIL wlerr_set got %b exp 1", wlast_err); end
        rd_mode = 0;
        axi_read(64'h4000, 8'h42, 8'd2, 3'd5);
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (rdat[k] !== wdat[k]) begin n_fail++; $display("FAIL wlerr_data beat %0d got %h exp %h", k, rdat[k], wdat[k]); end
        end
        fill(0);
        axi_write(64'h4400, 8'h43, 8'd0, 3'd5);
        n_cmp++; if (wlast_err !== 1'b1) begin n_fail++; $display("FAIL wlerr_sticky got %b exp 1", wlast_err); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        n_cmp++; if (wlast_err !== 1'b0) begin n_fail++; $display("FAIL wlerr_cleared got %b exp 0", wlast_err); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_mode = 0;
        test_reset();
        test_single();
        test_burst_backpressure();
        test_strobe();
        test_wrap();
        test_random();
        test_concurrent_reset();
        test_wlast_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
